rtc3w_seq: RTL and testbench



---
 rtl/rtc3w_pkg.sv | 52 +++++
 rtl/rtc3w_seq_tick.sv | 26 ++
 rtl/rtc3w_seq.sv | 213 +++++++++++++++++++++
 tb/tb_rtc3w_seq.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc3w_pkg.sv
// rtc3w_pkg: shared types and constants for the 3-wire RTC transaction sequencer.
// States, register map, STATUS/CTRL bit positions and the transaction phase count.
package rtc3w_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CE_SETUP = 3'd1,
    BIT_LO   = 3'd2,
    BIT_HI   = 3'd3,
    END      = 3'd4,
    HOLD     = 3'd5
  } state_t;

  localparam logic [2:0] ADDR_CMD    = 3'd0;
  localparam logic [2:0] ADDR_WDATA  = 3'd1;
  localparam logic [2:0] ADDR_RDATA  = 3'd2;
  localparam logic [2:0] ADDR_STATUS = 3'd3;
  localparam logic [2:0] ADDR_CTRL   = 3'd4;

  localparam int STS_BUSY    = 0;
  localparam int STS_DONE    = 1;
  localparam int STS_ABORTED = 2;

  localparam int CTRL_IRQ_EN = 0;
  localparam int CTRL_ABORT  = 1;

  // CE_SETUP + 16 x (BIT_LO, BIT_HI) + END + HOLD
  localparam int TXN_PHASES = 35;
  // command byte + data byte
  localparam int NUM_BITS   = 16;

  // one bus write request, as seen on a single clk
  typedef struct packed {
    logic       wr;
    logic [2:0] addr;
    logic [7:0] data;
  } bus_req_t;

  // pin drive bundle produced by the output decoder
  typedef struct packed {
    logic ce;
    logic sclk;
    logic oe;
    logic io;
  } pin_drv_t;

  function automatic logic [7:0] status_byte(input logic busy, input logic done,
                                             input logic aborted);
    return {5'b0, aborted, done, busy};
  endfunction

endpackage

// File: rtl/rtc3w_seq_tick.sv
// rtc3w_tick: loadable half-period down-counter. Loading sets it to CLK_DIV-1 and
// tc rises once it has counted down to 0, so each loaded phase lasts CLK_DIV cycles.
module rtc3w_tick #(
  parameter int CLK_DIV = 50
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  output logic tc
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  // reload on phase entry, otherwise count down and park at zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          cnt <= '0;
    else if (load)         cnt <= RELOAD;
    else if (cnt != '0)    cnt <= cnt - 1'b1;
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/rtc3w_seq.sv
// rtc3w_seq: Avalon-MM slave that sequences a full DS1302-style 3-wire transfer
// (command byte then data byte, LSB first) on CE / SCLK / IO.
// Optional build macro RTC3W_IRQ_EN adds the irq_en control bit and a registered
// completion interrupt; without it irq is tied low and CTRL bit0 reads 0.
module rtc3w_seq
  import rtc3w_pkg::*;
#(
  parameter int CLK_DIV = 50
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] address,
  input  logic       chipselect,
  input  logic       write_n,
  input  logic [7:0] writedata,
  output logic [7:0] readdata,
  output logic       irq,
  inout  wire        rtc_io,
  output logic       rtc_sclk,
  output logic       rtc_ce
);

  bus_req_t req;
  state_t   state, state_nxt;
  logic [3:0] bit_idx, bit_idx_nxt;
  logic       load, tc;
  logic       busy, done, aborted, abort_pend;
  logic [7:0] cmd, wdata, rdata, shift;
  pin_drv_t   pins;
  logic       oe;
  logic       wr_cmd, wr_wdata, wr_sts, wr_ctrl;
  logic       accept, abort_req, hold_exit;
  logic       irq_en_rd;

  assign req.wr   = chipselect & ~write_n;
  assign req.addr = address;
  assign req.data = writedata;

  assign wr_cmd   = req.wr && (req.addr == ADDR_CMD);
  assign wr_wdata = req.wr && (req.addr == ADDR_WDATA);
  assign wr_sts   = req.wr && (req.addr == ADDR_STATUS);
  assign wr_ctrl  = req.wr && (req.addr == ADDR_CTRL);

  assign accept    = wr_cmd && (state == IDLE);
  assign abort_req = wr_ctrl && req.data[CTRL_ABORT] && busy;
  assign hold_exit = (state == HOLD) && tc;

  rtc3w_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load),
    .tc      (tc)
  );

  // state and bit-position register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      bit_idx <= '0;
    end else begin
      state   <= state_nxt;
      bit_idx <= bit_idx_nxt;
    end
  end

  // phase sequencing; every transition reloads the half-period counter.
  // An abort already in HOLD does not restart HOLD, it only marks the exit as aborted.
  always_comb begin
    state_nxt   = state;
    bit_idx_nxt = bit_idx;
    load        = 1'b0;
    if (accept) begin
      state_nxt   = CE_SETUP;
      bit_idx_nxt = '0;
      load        = 1'b1;
    end else if (abort_req && (state != HOLD)) begin
      state_nxt = HOLD;
      load      = 1'b1;
    end else if ((state != IDLE) && tc) begin
      load = 1'b1;
      case (state)
        CE_SETUP: begin
          state_nxt   = BIT_LO;
          bit_idx_nxt = '0;
        end
        BIT_LO:   state_nxt = BIT_HI;
        BIT_HI: begin
          if (bit_idx == 4'(NUM_BITS - 1)) begin
            state_nxt = END;
          end else begin
            state_nxt   = BIT_LO;
            bit_idx_nxt = bit_idx + 4'd1;
          end
        end
        END:      state_nxt = HOLD;
        HOLD:     state_nxt = IDLE;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  // pin decode: the line is released only for data bits of a read, and oe is
  // constant across each BIT_LO/BIT_HI pair so it never moves while sclk is high
  always_comb begin
    pins = '0;
    case (state)
      CE_SETUP: begin
        pins.ce = 1'b1;
        pins.oe = 1'b1;
        pins.io = cmd[0];
      end
      BIT_LO, BIT_HI: begin
        pins.ce   = 1'b1;
        pins.sclk = (state == BIT_HI);
        if (!bit_idx[3]) begin
          pins.oe = 1'b1;
          pins.io = cmd[bit_idx[2:0]];
        end else if (!cmd[0]) begin
          pins.oe = 1'b1;
          pins.io = wdata[bit_idx[2:0]];
        end
      end
      END:      pins.ce = 1'b1;
      default:  pins = '0;
    endcase
  end

  assign rtc_ce   = pins.ce;
  assign rtc_sclk = pins.sclk;
  assign oe       = pins.oe;
  assign rtc_io   = pins.oe ? pins.io : 1'bz;

  // read data capture on the last cycle of each read-data low phase
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      shift <= '0;
    else if ((state == BIT_LO) && bit_idx[3] && cmd[0] && tc)
      shift[bit_idx[2:0]] <= rtc_io;
  end

  // host registers and completion flags; flag sets are written last so they win
  // over a STATUS clear on the same edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd        <= '0;
      wdata      <= '0;
      rdata      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      abort_pend <= 1'b0;
    end else begin
      if (wr_wdata && !busy) wdata <= req.data;
      if (wr_sts) begin
        if (req.data[STS_DONE])    done    <= 1'b0;
        if (req.data[STS_ABORTED]) aborted <= 1'b0;
      end
      if (abort_req) abort_pend <= 1'b1;
      if (accept) begin
        cmd        <= req.data;
        busy       <= 1'b1;
        done       <= 1'b0;
        aborted    <= 1'b0;
        abort_pend <= 1'b0;
      end else if (hold_exit) begin
        busy       <= 1'b0;
        abort_pend <= 1'b0;
        if (abort_pend || abort_req) begin
          aborted <= 1'b1;
        end else begin
          done <= 1'b1;
          if (cmd[0]) rdata <= shift;
        end
      end
    end
  end

`ifdef RTC3W_IRQ_EN
  logic irq_en;

  // interrupt enable and registered completion interrupt
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (wr_ctrl) irq_en <= req.data[CTRL_IRQ_EN];
      irq <= done & irq_en;
    end
  end

  assign irq_en_rd = irq_en;
`else
  assign irq       = 1'b0;
  assign irq_en_rd = 1'b0;
`endif

  // registered read mux, refreshed every clk from the current address
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      case (address)
        ADDR_WDATA:  readdata <= wdata;
        ADDR_RDATA:  readdata <= rdata;
        ADDR_STATUS: readdata <= status_byte(busy, done, aborted);
        ADDR_CTRL:   readdata <= {7'b0, irq_en_rd};
        default:     readdata <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_rtc3w_seq.sv
// tb_rtc3w_seq: directed + randomized bench for rtc3w_seq with an RTC pin model
// that records the line at each SCLK rise and drives read data after SCLK falls.
`timescale 1ns/1ps
module tb_rtc3w_seq;

  localparam int CLK_DIV  = 4;
  localparam int BUSY_CYC = 35 * CLK_DIV;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] address = '0;
  logic       chipselect = 1'b0;
  logic       write_n = 1'b1;
  logic [7:0] writedata = '0;
  logic [7:0] readdata;
  logic       irq;
  wire        rtc_io;
  logic       rtc_sclk, rtc_ce;

  logic model_oe = 1'b0, model_bit = 1'b0, model_rd = 1'b0;
  logic [7:0] model_byte = '0;
  assign rtc_io = model_oe ? model_bit : 1'bz;

  rtc3w_seq #(.CLK_DIV(CLK_DIV)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .rtc_io     (rtc_io),
    .rtc_sclk   (rtc_sclk),
    .rtc_ce     (rtc_ce)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int rises = 0, falls = 0, oe_viol = 0, contention = 0, irq_high = 0;
  logic rise_io [16];
  logic rise_oe [16];
  logic sclk_q = 1'b0, ce_q = 1'b0, oe_q = 1'b0;
  logic [7:0] exp_rdata = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // RTC pin model: per-transaction rise log, read-data drive, protocol watch
  always @(negedge clk) begin
    if (rtc_ce && !ce_q) begin
      rises = 0;
      falls = 0;
    end
    if (rtc_sclk && !sclk_q) begin
      if (rises < 16) begin
        rise_io[rises] = rtc_io;
        rise_oe[rises] = dut.oe;
      end
      rises++;
    end
    if (!rtc_sclk && sclk_q) begin
      falls++;
      if (model_rd && falls >= 8 && falls < 16) begin
        model_oe  = 1'b1;
        model_bit = model_byte[falls-8];
      end else begin
        model_oe = 1'b0;
      end
    end
    if (!rtc_ce) model_oe = 1'b0;
    if (rtc_sclk && sclk_q && (dut.oe !== oe_q)) oe_viol++;
    if (model_oe && dut.oe) contention++;
    if (irq !== 1'b0) irq_high++;
    sclk_q = rtc_sclk;
    ce_q   = rtc_ce;
    oe_q   = dut.oe;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic write_reg(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(posedge clk);
    #1;
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic read_reg(input logic [2:0] a, output logic [7:0] d);
    @(negedge clk);
    address = a;
    @(posedge clk);
    @(negedge clk);
    d = readdata;
  endtask

  // counts cycles STATUS.busy is seen high; called right after the CMD write
  task automatic measure_busy(output int n);
    n = 0;
    address = 3'd3;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (readdata[0]) n++;
      else if (n > 0) break;
    end
  endtask

  task automatic wait_idle(input string tag);
    int waited;
    waited = 0;
    address = 3'd3;
    repeat (2) @(negedge clk);
    while (readdata[0] && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    assert (waited < 2000) else begin
      errors++;
      $error("FAIL %s: busy still set after %0d cycles", tag, waited);
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] c, input logic [7:0] w,
                                   input logic [7:0] r, input int i);
    if (i < 8) return c[i];
    return c[0] ? r[i-8] : w[i-8];
  endfunction

  task automatic check_bits(input string tag, input logic [7:0] c, input logic [7:0] w,
                            input logic [7:0] r);
    check({tag, " rises"}, rises, 16);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("%s io%0d", tag, i), rise_io[i], exp_bit(c, w, r, i));
      check($sformatf("%s oe%0d", tag, i), rise_oe[i], (i < 8 || !c[0]) ? 1 : 0);
    end
  endtask

  task automatic do_txn(input string tag, input logic [7:0] c, input logic [7:0] w,
                        input logic [7:0] r);
    int n;
    logic [7:0] d;
    model_rd = c[0]; model_byte = r;
    write_reg(3'd1, w);
    write_reg(3'd0, c);
    measure_busy(n);
    check({tag, " busy"}, n, BUSY_CYC);
    check_bits(tag, c, w, r);
    read_reg(3'd3, d);
    check({tag, " status"}, d, 8'h02);
    if (c[0]) exp_rdata = r;
    read_reg(3'd2, d);
    check({tag, " rdata"}, d, exp_rdata);
    read_reg(3'd1, d);
    check({tag, " wdata"}, d, w);
  endtask

  initial begin
    logic [7:0] d;
    int ra;
    repeat (3) @(posedge clk);
    #1;
    check("rst readdata", readdata, 0);
    check("rst ce", rtc_ce, 0);
    check("rst sclk", rtc_sclk, 0);
    check("rst oe", dut.oe, 0);
    check("rst irq", irq, 0);
    @(negedge clk) reset_n = 1'b1;
    read_reg(3'd3, d); check("rst status", d, 0);
    read_reg(3'd2, d); check("rst rdata", d, 0);
    read_reg(3'd4, d); check("rst ctrl", d, 0);

    do_txn("wr55", 8'h80, 8'h55, 8'h00);
    do_txn("rdA3", 8'h81, 8'h00, 8'hA3);

    for (int k = 0; k < 6; k++) begin
      logic [7:0] c, w, r;
      c = 8'($urandom); w = 8'($urandom); r = 8'($urandom);
      do_txn($sformatf("rnd%0d", k), c, w, r);
    end

    // CMD and WDATA writes while busy are dropped
    model_rd = 1'b0;
    write_reg(3'd1, 8'h3C);
    write_reg(3'd0, 8'h80);
    repeat (18) @(posedge clk);
    write_reg(3'd0, 8'h81);
    write_reg(3'd1, 8'hFF);
    wait_idle("ign idle");
    check_bits("ign", 8'h80, 8'h3C, 8'h00);
    read_reg(3'd1, d); check("ign wdata", d, 8'h3C);
    read_reg(3'd3, d); check("ign status", d, 8'h02);

    // abort a read at cycle 50
    model_rd = 1'b1; model_byte = 8'h5E;
    write_reg(3'd0, 8'h81);
    repeat (49) @(posedge clk);
    write_reg(3'd4, 8'h02);
    check("abt ce", rtc_ce, 0);
    check("abt sclk", rtc_sclk, 0);
    check("abt oe", dut.oe, 0);
    ra = rises;
    check("abt rises", ra, 50 / (2 * CLK_DIV));
    address = 3'd3;
    repeat (4) @(posedge clk);
    #1 check("abt status busy", readdata, 8'h01);
    @(posedge clk);
    #1 check("abt status", readdata, 8'h04);
    repeat (10) @(posedge clk);
    check("abt rises held", rises, ra);
    read_reg(3'd2, d); check("abt rdata", d, exp_rdata);
    write_reg(3'd4, 8'h02);
    read_reg(3'd3, d); check("idle abort status", d, 8'h04);
    read_reg(3'd4, d); check("ctrl abort bit", d & 8'h02, 0);
    write_reg(3'd3, 8'h04);
    read_reg(3'd3, d); check("status clear", d, 8'h00);

    // async reset mid-transfer
    model_rd = 1'b0;
    write_reg(3'd1, 8'h11);
    write_reg(3'd0, 8'h80);
    repeat (69) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("mid rst ce", rtc_ce, 0);
    check("mid rst sclk", rtc_sclk, 0);
    check("mid rst oe", dut.oe, 0);
    check("mid rst readdata", readdata, 0);
    @(negedge clk) reset_n = 1'b1;
    read_reg(3'd3, d); check("post rst status", d, 0);
    read_reg(3'd2, d); check("post rst rdata", d, 0);
    exp_rdata = 8'h00;
    do_txn("post rst", 8'h81, 8'h00, 8'($urandom));

`ifdef RTC3W_IRQ_EN
    write_reg(3'd4, 8'h01);
    read_reg(3'd4, d); check("irq ctrl", d, 8'h01);
    write_reg(3'd3, 8'h02);
    repeat (2) @(posedge clk);
    #1 check("irq idle", irq, 0);
    do_txn("irq txn", 8'h80, 8'hC3, 8'h00);
    check("irq set", irq, 1);
    write_reg(3'd3, 8'h02);
    @(posedge clk);
    #1 check("irq clr", irq, 0);
    do_txn("irq txn2", 8'h80, 8'h3A, 8'h00);
    check("irq set2", irq, 1);
    write_reg(3'd4, 8'h00);
    @(posedge clk);
    #1 check("irq en clr", irq, 0);
    read_reg(3'd3, d); check("irq done kept", d, 8'h02);
`else
    write_reg(3'd4, 8'h01);
    read_reg(3'd4, d); check("ctrl no irq", d, 8'h00);
    do_txn("noirq txn", 8'h80, 8'hC3, 8'h00);
    check("irq never", irq_high, 0);
`endif

    check("oe stable sclk hi", oe_viol, 0);
    check("io contention", contention, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
